psram_fetch_scheduler: RTL and testbench
========================================

Name: psram_fetch_scheduler

Overview:
- Sequences burst reads from the PSRAM memory controller and shares its single read port between two requesters.
  - The VGA line fetcher fills a ping-pong line buffer, one display line per request.
  - The debug/SSD single-word reader returns one 16-bit word per request.
- Sits between the VGA/SSD logic and the memory controller.
- Computes burst addresses from the selected image and the requested line.

Parameters:
- WORDS_PER_LINE, 64: 16-bit words per line burst (1..128).
- IMG_STRIDE, 23'h004000: word-address distance between image bases.
- LINE_STRIDE, 64: word-address distance between consecutive lines.
- STARVE_LIMIT, 4: consecutive line grants allowed while a debug request waits.

Ports:
- sys_clk in 1: system clock.
- Reset in 1: asynchronous, active-high reset.
- img_sel in 2: image select; sampled at line grant.
- line_req in 1: one-cycle pulse, fetch line line_num.
- line_num in 7: display line index.
- line_busy out 1: a line fetch is pending or in flight.
- line_ready out 1: one-cycle pulse, line fully written.
- line_bank out 1: bank holding the most recently completed line.
- lb_we out 1: line-buffer write strobe.
- lb_waddr out 8: {bank, word index[6:0]}.
- lb_wdata out 16: word to line buffer.
- dbg_req in 1: one-cycle pulse, single-word read.
- dbg_addr in 23: word address for debug read.
- dbg_valid out 1: one-cycle pulse, dbg_rdata valid.
- dbg_rdata out 16: debug read data, held until next dbg_valid.
- mem_req out 1: burst request, held until mem_ack.
- mem_addr out 23: burst start address.
- mem_len out 8: burst length in words.
- mem_ack in 1: controller accepted the request.
- mem_dvalid in 1: mem_data valid this cycle.
- mem_data in 16: read data.
- mem_done in 1: burst complete.
- overrun out 1: sticky, a line request was overwritten while pending.
- len_err out 1: sticky, mem_done arrived with word count != mem_len.

Behaviour:
- Reset: all outputs 0, FSM IDLE, pending flags clear, write bank 0, starve counter 0.
- Request latching:
  - line_req/dbg_req each set a one-deep pending flag and latch their argument.
  - A line_req arriving while a line is already pending overwrites line_num and sets overrun.
  - A dbg_req while a debug read is pending is ignored.
  - A request pulse on the same cycle its pending flag clears at grant becomes the new pending request.
- FSM states: IDLE, REQ, BURST, FINISH.
- IDLE -> REQ when any request is pending.
  - Arbitration is evaluated in IDLE only; line wins.
  - Exception: debug wins when debug is pending and starve_cnt == STARVE_LIMIT.
  - starve_cnt increments on each line grant while debug is pending; it clears on a debug grant.
- Line grant:
  - mem_addr = img_sel*IMG_STRIDE + line_num*LINE_STRIDE, mod 2^23.
  - mem_len = WORDS_PER_LINE.
  - Write bank = ~line_bank.
  - img_sel and line_num are frozen for the rest of the burst.
- Debug grant: mem_addr = dbg_addr, mem_len = 1.
- REQ: mem_req = 1 and mem_addr/mem_len stable until mem_ack; then mem_req drops next cycle and the FSM enters BURST.
- BURST:
  - Line burst: each mem_dvalid drives lb_we = 1 in the same cycle (combinational pass-through).
    - lb_waddr = {bank, cnt}; lb_wdata = mem_data; cnt increments.
  - Debug burst: the first mem_dvalid loads dbg_rdata.
- BURST -> FINISH on mem_done.
  - The mem_done cycle also accepts a coincident mem_dvalid.
  - mem_dvalid beyond mem_len is dropped (no lb_we) and sets len_err.
  - Fewer words than mem_len also sets len_err.
- FINISH, one cycle:
  - Line: line_bank <= write bank and line_ready pulses, even if len_err was set.
  - Debug: dbg_valid pulses.
  - Then -> IDLE, giving 1 idle cycle minimum between bursts.
- line_busy = pending line OR line burst in REQ/BURST/FINISH.
- Latency: line_req in IDLE -> mem_req asserted 1 cycle later.
- Reset mid-burst:
  - Immediate return to IDLE; mem_req = 0.
  - Partial line is discarded; line_bank is not toggled.
  - Sticky flags are cleared.
- mem_ack/mem_dvalid/mem_done outside their expected states are ignored.

Decomposition:
- Shared package fetch_pkg holds:
  - FSM state encoding.
  - Requester ID enum (REQ_LINE, REQ_DBG).
  - Address width 23 and data width 16 constants.
- One sub-module, fetch_arbiter: the two pending flags, the starvation counter and grant selection.
- The FSM and datapath live in the top block.

Test Plan:
1. Line fetch: img_sel = 1, line_req with line_num = 3 -> mem_addr = 0x0040C0, mem_len = 64.
   - 64 mem_dvalid words 0x0000..0x003F -> lb_waddr 0x80..0xBF with matching data.
   - line_ready pulses once; line_bank = 1.
2. Debug read: dbg_req at addr 0x000123, controller returns 0xBEEF -> mem_len = 1, dbg_rdata = 0xBEEF, one dbg_valid, no lb_we.
3. Simultaneous line_req and dbg_req in IDLE -> line granted first, then debug after FINISH/IDLE.
   - Streaming line_reqs with debug pending -> debug granted after exactly 4 line grants.
4. Two line_reqs while busy (line_num 5 then 9) -> next burst uses line 9; overrun = 1.
5. Controller sends 63 words then mem_done -> len_err = 1; line_ready still pulses.
   - 65 words -> 65th dropped, len_err = 1.
6. Reset asserted after 10 words of a line burst -> mem_req = 0, FSM IDLE, line_bank unchanged.
   - Next line_req starts a fresh burst at the correct address.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the PSRAM fetch scheduler.
package fetch_pkg;

   localparam int unsigned ADDR_W = 23;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_BURST,
      ST_FINISH
   } fetch_state_t;

   typedef enum logic {
      REQ_LINE,
      REQ_DBG
   } req_id_t;

endpackage

// File: rtl/fetch_arbiter.sv
// Pending-request latches, starvation counter and line/debug grant selection.
module fetch_arbiter
   import fetch_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              sys_clk,
   input  logic              Reset,
   input  logic              lineReq,
   input  logic [6:0]        lineNum,
   input  logic              dbgReq,
   input  logic [ADDR_W-1:0] dbgAddr,
   input  logic              grantEn,
   output logic              grant,
   output req_id_t           grantId,
   output logic [6:0]        grantLineNum,
   output logic [ADDR_W-1:0] grantDbgAddr,
   output logic              linePend,
   output logic              overrun
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

   logic              dbgPend;
   logic [6:0]        pendLineNum;
   logic [ADDR_W-1:0] pendDbgAddr;
   logic [SW-1:0]     starveCnt;
   logic              anyLine, anyDbg, lineGrant, dbgGrant;

   // A fresh pulse in IDLE is granted directly so mem_req follows one cycle later.
   always_comb begin
      anyLine      = linePend | lineReq;
      anyDbg       = dbgPend | dbgReq;
      grant        = grantEn & (anyLine | anyDbg);
      grantId      = (anyDbg && (!anyLine || starveCnt == SW'(STARVE_LIMIT))) ? REQ_DBG : REQ_LINE;
      lineGrant    = grant && (grantId == REQ_LINE);
      dbgGrant     = grant && (grantId == REQ_DBG);
      grantLineNum = linePend ? pendLineNum : lineNum;
      grantDbgAddr = dbgPend ? pendDbgAddr : dbgAddr;
   end

   always_ff @(posedge sys_clk or posedge Reset) begin
      if (Reset) begin
         linePend    <= 1'b0;
         dbgPend     <= 1'b0;
         pendLineNum <= '0;
         pendDbgAddr <= '0;
         starveCnt   <= '0;
         overrun     <= 1'b0;
      end else begin
         linePend <= lineGrant ? (linePend & lineReq) : (linePend | lineReq);
         if (lineReq)
            pendLineNum <= lineNum;
         if (lineReq && linePend && !lineGrant)
            overrun <= 1'b1;
         dbgPend <= dbgGrant ? (dbgPend & dbgReq) : (dbgPend | dbgReq);
         if (dbgReq && (!dbgPend || dbgGrant))
            pendDbgAddr <= dbgAddr;
         if (dbgGrant)
            starveCnt <= '0;
         else if (lineGrant && anyDbg && starveCnt != SW'(STARVE_LIMIT))
            starveCnt <= starveCnt + 1'b1;
      end
   end

endmodule

// File: rtl/psram_fetch_scheduler.sv
// Shares the PSRAM controller read port between the VGA line fetcher and the debug word reader.
module psram_fetch_scheduler
   import fetch_pkg::*;
#(
   parameter int unsigned       WORDS_PER_LINE = 64,
   parameter logic [ADDR_W-1:0] IMG_STRIDE     = 23'h004000,
   parameter int unsigned       LINE_STRIDE    = 64,
   parameter int unsigned       STARVE_LIMIT   = 4
) (
   input  logic              sys_clk,
   input  logic              Reset,
   input  logic [1:0]        img_sel,
   input  logic              line_req,
   input  logic [6:0]        line_num,
   output logic              line_busy,
   output logic              line_ready,
   output logic              line_bank,
   output logic              lb_we,
   output logic [7:0]        lb_waddr,
   output logic [DATA_W-1:0] lb_wdata,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_valid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_len,
   input  logic              mem_ack,
   input  logic              mem_dvalid,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_done,
   output logic              overrun,
   output logic              len_err
);

   fetch_state_t      state, stateNext;
   req_id_t           curId, grantId;
   logic              grant, linePend, wrBank, accept;
   logic [6:0]        grantLineNum;
   logic [ADDR_W-1:0] grantDbgAddr, lineAddr;
   logic [7:0]        cnt, cntNext;

   fetch_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arbiter (
      .sys_clk      (sys_clk),
      .Reset        (Reset),
      .lineReq      (line_req),
      .lineNum      (line_num),
      .dbgReq       (dbg_req),
      .dbgAddr      (dbg_addr),
      .grantEn      (state == ST_IDLE),
      .grant        (grant),
      .grantId      (grantId),
      .grantLineNum (grantLineNum),
      .grantDbgAddr (grantDbgAddr),
      .linePend     (linePend),
      .overrun      (overrun)
   );

   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE:   if (grant) stateNext = ST_REQ;
         ST_REQ:    if (mem_ack) stateNext = ST_BURST;
         ST_BURST:  if (mem_done) stateNext = ST_FINISH;
         ST_FINISH: stateNext = ST_IDLE;
         default:   stateNext = ST_IDLE;
      endcase

      lineAddr   = ADDR_W'(32'(img_sel) * 32'(IMG_STRIDE) + 32'(grantLineNum) * 32'(LINE_STRIDE));
      accept     = (state == ST_BURST) && mem_dvalid && (cnt < mem_len);
      cntNext    = cnt + 8'(accept);
      mem_req    = (state == ST_REQ);
      lb_we      = accept && (curId == REQ_LINE);
      lb_waddr   = lb_we ? {wrBank, cnt[6:0]} : '0;
      lb_wdata   = lb_we ? mem_data : '0;
      line_ready = (state == ST_FINISH) && (curId == REQ_LINE);
      dbg_valid  = (state == ST_FINISH) && (curId == REQ_DBG);
      line_busy  = linePend || ((state != ST_IDLE) && (curId == REQ_LINE));
   end

   always_ff @(posedge sys_clk or posedge Reset) begin
      if (Reset) begin
         state     <= ST_IDLE;
         curId     <= REQ_LINE;
         mem_addr  <= '0;
         mem_len   <= '0;
         wrBank    <= 1'b0;
         line_bank <= 1'b0;
         cnt       <= '0;
         dbg_rdata <= '0;
         len_err   <= 1'b0;
      end else begin
         state <= stateNext;
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  curId <= grantId;
                  cnt   <= '0;
                  if (grantId == REQ_LINE) begin
                     mem_addr <= lineAddr;
                     mem_len  <= 8'(WORDS_PER_LINE);
                     wrBank   <= ~line_bank;
                  end else begin
                     mem_addr <= grantDbgAddr;
                     mem_len  <= 8'd1;
                  end
               end
            end
            ST_BURST: begin
               cnt <= cntNext;
               if (accept && curId == REQ_DBG && cnt == 8'd0)
                  dbg_rdata <= mem_data;
               // Excess words are dropped; a short burst is caught on mem_done.
               if (mem_dvalid && !accept)
                  len_err <= 1'b1;
               if (mem_done && cntNext != mem_len)
                  len_err <= 1'b1;
            end
            ST_FINISH: begin
               if (curId == REQ_LINE)
                  line_bank <= wrBank;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_fetch_scheduler.sv
// Self-checking bench: bench-side controller responder plus a behavioural address/bank model.
module tb_psram_fetch_scheduler;

   localparam int unsigned WPL  = 64;
   localparam int unsigned SLIM = 4;

   logic        sys_clk = 1'b0;
   logic        Reset;
   logic [1:0]  img_sel;
   logic        line_req;
   logic [6:0]  line_num;
   logic        line_busy, line_ready, line_bank, lb_we;
   logic [7:0]  lb_waddr;
   logic [15:0] lb_wdata;
   logic        dbg_req;
   logic [22:0] dbg_addr;
   logic        dbg_valid;
   logic [15:0] dbg_rdata;
   logic        mem_req;
   logic [22:0] mem_addr;
   logic [7:0]  mem_len;
   logic        mem_ack, mem_dvalid, mem_done;
   logic [15:0] mem_data;
   logic        overrun, len_err;

   int vectors = 0;
   int errors  = 0;
   logic [7:0]  qAddr[$];
   logic [15:0] qData[$];

   always #5 sys_clk = ~sys_clk;

   psram_fetch_scheduler #(
      .WORDS_PER_LINE (WPL),
      .IMG_STRIDE     (23'h004000),
      .LINE_STRIDE    (64),
      .STARVE_LIMIT   (SLIM)
   ) dut (
      .sys_clk    (sys_clk),
      .Reset      (Reset),
      .img_sel    (img_sel),
      .line_req   (line_req),
      .line_num   (line_num),
      .line_busy  (line_busy),
      .line_ready (line_ready),
      .line_bank  (line_bank),
      .lb_we      (lb_we),
      .lb_waddr   (lb_waddr),
      .lb_wdata   (lb_wdata),
      .dbg_req    (dbg_req),
      .dbg_addr   (dbg_addr),
      .dbg_valid  (dbg_valid),
      .dbg_rdata  (dbg_rdata),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_len    (mem_len),
      .mem_ack    (mem_ack),
      .mem_dvalid (mem_dvalid),
      .mem_data   (mem_data),
      .mem_done   (mem_done),
      .overrun    (overrun),
      .len_err    (len_err)
   );

   function automatic logic [22:0] refLineAddr(input int unsigned img, input int unsigned num);
      return 23'((img * 32'h4000 + num * 64) % 32'h800000);
   endfunction

   task automatic do_reset();
      Reset = 1'b1; line_req = 1'b0; dbg_req = 1'b0;
      mem_ack = 1'b0; mem_dvalid = 1'b0; mem_done = 1'b0; mem_data = '0;
      @(negedge sys_clk); @(negedge sys_clk);
      Reset = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic pulse_line(input logic [1:0] img, input logic [6:0] num);
      img_sel = img; line_num = num; line_req = 1'b1;
      @(negedge sys_clk);
      line_req = 1'b0;
   endtask

   task automatic pulse_dbg(input logic [22:0] a);
      dbg_addr = a; dbg_req = 1'b1;
      @(negedge sys_clk);
      dbg_req = 1'b0;
   endtask

   // Acts as the memory controller for one burst, recording line-buffer writes.
   task automatic serve(input int unsigned nWords, input logic [15:0] base,
                        output bit got, output logic [22:0] addr, output logic [7:0] len,
                        output logic rdy, output logic vld, output logic reqAfterAck);
      got = 0; addr = '0; len = '0; rdy = 0; vld = 0; reqAfterAck = 0;
      qAddr.delete(); qData.delete();
      for (int i = 0; i < 50; i++) begin
         if (mem_req) begin got = 1; break; end
         @(negedge sys_clk);
      end
      if (!got) return;
      addr = mem_addr; len = mem_len;
      mem_ack = 1'b1;
      @(negedge sys_clk);
      mem_ack = 1'b0;
      reqAfterAck = mem_req;
      for (int unsigned w = 0; w < nWords; w++) begin
         mem_dvalid = 1'b1; mem_data = base + 16'(w); mem_done = (w == nWords - 1);
         #1;
         if (lb_we) begin qAddr.push_back(lb_waddr); qData.push_back(lb_wdata); end
         @(negedge sys_clk);
      end
      mem_dvalid = 1'b0; mem_done = 1'b0;
      rdy = line_ready; vld = dbg_valid;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({mem_req, line_busy, line_ready, line_bank, lb_we, dbg_valid, overrun, len_err, mem_addr, mem_len, dbg_rdata} !== '0) begin
         errors++; $display("FAIL reset_outputs: got req=%b busy=%b rdy=%b bank=%b we=%b vld=%b ovr=%b lerr=%b addr=%h len=%h rdata=%h, want all 0",
                            mem_req, line_busy, line_ready, line_bank, lb_we, dbg_valid, overrun, len_err, mem_addr, mem_len, dbg_rdata);
      end
      mem_ack = 1'b1; mem_dvalid = 1'b1; mem_done = 1'b1; mem_data = 16'hFFFF;
      #1;
      vectors++;
      if (lb_we !== 1'b0) begin errors++; $display("FAIL stray_idle_we: got %b want 0", lb_we); end
      @(negedge sys_clk); @(negedge sys_clk);
      mem_ack = 1'b0; mem_dvalid = 1'b0; mem_done = 1'b0;
      vectors++;
      if ({mem_req, len_err, line_ready, dbg_valid} !== 4'b0) begin
         errors++; $display("FAIL stray_idle_inputs: got req/lerr/rdy/vld=%b want 0000", {mem_req, len_err, line_ready, dbg_valid});
      end
   endtask

   task automatic test_line_fetch();
      bit got; logic [22:0] a; logic [7:0] l; logic rdy, vld, rq; int bad;
      do_reset();
      pulse_line(2'd1, 7'd3);
      vectors++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL line_latency: mem_req got %b want 1", mem_req); end
      serve(WPL, 16'h0000, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || a !== 23'h0040C0 || l !== 8'd64) begin
         errors++; $display("FAIL line_request: got req=%0d addr=%h len=%0d want 1 0040c0 64", got, a, l);
      end
      vectors++;
      if (rq !== 1'b0) begin errors++; $display("FAIL req_drop: mem_req after ack got %b want 0", rq); end
      bad = (qAddr.size() != WPL) ? 1 : 0;
      for (int i = 0; i < qAddr.size(); i++)
         if (qAddr[i] !== 8'(8'h80 + i) || qData[i] !== 16'(i)) bad++;
      vectors++;
      if (bad != 0) begin errors++; $display("FAIL line_writes: got %0d writes, %0d bad, want 64 at 80..bf", qAddr.size(), bad); end
      vectors++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL line_ready: got %b want 1", rdy); end
      @(negedge sys_clk);
      vectors++;
      if ({line_ready, line_bank, len_err, line_busy} !== 4'b0100) begin
         errors++; $display("FAIL line_after: got rdy/bank/lerr/busy=%b want 0100", {line_ready, line_bank, len_err, line_busy});
      end
   endtask

   task automatic test_debug_read();
      bit got; logic [22:0] a; logic [7:0] l; logic rdy, vld, rq;
      pulse_dbg(23'h000123);
      dbg_addr = 23'h7FFFFF;
      serve(1, 16'hBEEF, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || a !== 23'h000123 || l !== 8'd1) begin
         errors++; $display("FAIL dbg_request: got req=%0d addr=%h len=%0d want 1 000123 1", got, a, l);
      end
      vectors++;
      if (vld !== 1'b1 || dbg_rdata !== 16'hBEEF || qAddr.size() != 0) begin
         errors++; $display("FAIL dbg_data: got vld=%b rdata=%h writes=%0d want 1 beef 0", vld, dbg_rdata, qAddr.size());
      end
      @(negedge sys_clk);
      vectors++;
      if (dbg_valid !== 1'b0 || dbg_rdata !== 16'hBEEF || line_bank !== 1'b1) begin
         errors++; $display("FAIL dbg_hold: got vld=%b rdata=%h bank=%b want 0 beef 1", dbg_valid, dbg_rdata, line_bank);
      end
   endtask

   task automatic test_arbitration();
      bit got; logic [22:0] a, da; logic [7:0] l; logic rdy, vld, rq;
      int unsigned nLines; bit dbgDone;
      do_reset();
      da = 23'($urandom);
      img_sel = 2'd2; line_num = 7'd11; dbg_addr = da;
      line_req = 1'b1; dbg_req = 1'b1;
      @(negedge sys_clk);
      line_req = 1'b0; dbg_req = 1'b0; dbg_addr = ~da;
      serve(WPL, 16'h1000, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || a !== refLineAddr(2, 11) || l !== 8'(WPL)) begin
         errors++; $display("FAIL arb_line_first: got addr=%h len=%0d want %h %0d", a, l, refLineAddr(2, 11), WPL);
      end
      serve(1, 16'h55AA, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || a !== da || l !== 8'd1 || dbg_rdata !== 16'h55AA) begin
         errors++; $display("FAIL arb_dbg_second: got addr=%h len=%0d rdata=%h want %h 1 55aa", a, l, dbg_rdata, da);
      end

      do_reset();
      img_sel = 2'd0; line_num = 7'd0; dbg_addr = da;
      line_req = 1'b1; dbg_req = 1'b1;
      @(negedge sys_clk);
      line_req = 1'b0; dbg_req = 1'b0;
      nLines = 0; dbgDone = 0;
      for (int k = 0; k < 10 && !dbgDone; k++) begin
         for (int i = 0; i < 50 && !mem_req; i++) @(negedge sys_clk);
         if (mem_req && mem_len == 8'd1) begin
            serve(1, 16'h0BAD, got, a, l, rdy, vld, rq);
            dbgDone = 1;
         end else begin
            pulse_line(2'd0, 7'(k + 1));
            serve(WPL, 16'h2000, got, a, l, rdy, vld, rq);
            if (got) nLines++;
         end
      end
      vectors++;
      if (!dbgDone || nLines != SLIM) begin
         errors++; $display("FAIL starvation: got dbg_served=%0d after %0d line grants want 1 after %0d", dbgDone, nLines, SLIM);
      end
      serve(WPL, 16'h3000, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || l !== 8'(WPL)) begin errors++; $display("FAIL starvation_drain: got req=%0d len=%0d want 1 %0d", got, l, WPL); end
   endtask

   task automatic test_overrun();
      bit got; logic [22:0] a; logic [7:0] l; logic rdy, vld, rq;
      do_reset();
      pulse_line(2'd0, 7'd0);
      pulse_line(2'd0, 7'd5);
      pulse_line(2'd0, 7'd9);
      vectors++;
      if (overrun !== 1'b1 || line_busy !== 1'b1) begin
         errors++; $display("FAIL overrun_flag: got ovr=%b busy=%b want 1 1", overrun, line_busy);
      end
      serve(WPL, 16'h0, got, a, l, rdy, vld, rq);
      serve(WPL, 16'h0, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || a !== refLineAddr(0, 9)) begin errors++; $display("FAIL overrun_line: got addr=%h want %h", a, refLineAddr(0, 9)); end
      repeat (4) @(negedge sys_clk);
      vectors++;
      if (mem_req !== 1'b0 || line_busy !== 1'b0 || overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_drain: got req=%b busy=%b ovr=%b want 0 0 1", mem_req, line_busy, overrun);
      end
   endtask

   task automatic test_len_err();
      bit got; logic [22:0] a; logic [7:0] l; logic rdy, vld, rq;
      do_reset();
      pulse_line(2'd2, 7'd7);
      serve(WPL - 1, 16'h4000, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || len_err !== 1'b1 || rdy !== 1'b1 || qAddr.size() != WPL - 1) begin
         errors++; $display("FAIL short_burst: got lerr=%b rdy=%b writes=%0d want 1 1 %0d", len_err, rdy, qAddr.size(), WPL - 1);
      end
      @(negedge sys_clk);
      vectors++;
      if (line_bank !== 1'b1) begin errors++; $display("FAIL short_bank: got %b want 1", line_bank); end
      do_reset();
      vectors++;
      if (len_err !== 1'b0) begin errors++; $display("FAIL len_err_reset: got %b want 0", len_err); end
      pulse_line(2'd2, 7'd8);
      serve(WPL + 1, 16'h5000, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || len_err !== 1'b1 || rdy !== 1'b1 || qAddr.size() != WPL) begin
         errors++; $display("FAIL long_burst: got lerr=%b rdy=%b writes=%0d want 1 1 %0d", len_err, rdy, qAddr.size(), WPL);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit got; logic [22:0] a; logic [7:0] l; logic rdy, vld, rq;
      do_reset();
      pulse_line(2'd1, 7'd20);
      mem_ack = 1'b1;
      @(negedge sys_clk);
      mem_ack = 1'b0;
      for (int w = 0; w < 10; w++) begin
         mem_dvalid = 1'b1; mem_data = 16'(w);
         @(negedge sys_clk);
      end
      Reset = 1'b1;
      #1;
      vectors++;
      if ({mem_req, lb_we, line_busy, line_bank, line_ready} !== 5'b0) begin
         errors++; $display("FAIL mid_reset: got req/we/busy/bank/rdy=%b want 00000", {mem_req, lb_we, line_busy, line_bank, line_ready});
      end
      @(negedge sys_clk);
      mem_dvalid = 1'b0;
      Reset = 1'b0;
      @(negedge sys_clk);
      pulse_line(2'd3, 7'd100);
      serve(WPL, 16'h6000, got, a, l, rdy, vld, rq);
      vectors++;
      if (!got || a !== 23'h00D900 || qAddr.size() != WPL || qAddr[0] !== 8'h80) begin
         errors++; $display("FAIL after_reset_burst: got addr=%h writes=%0d want 00d900 %0d from 80", a, qAddr.size(), WPL);
      end
      @(negedge sys_clk);
      vectors++;
      if (line_bank !== 1'b1 || len_err !== 1'b0) begin
         errors++; $display("FAIL after_reset_bank: got bank=%b lerr=%b want 1 0", line_bank, len_err);
      end
   endtask

   task automatic test_random();
      bit got; logic [22:0] a, da; logic [7:0] l; logic rdy, vld, rq;
      logic [1:0] img; logic [6:0] num; logic [15:0] base; logic mBank; int bad;
      do_reset();
      mBank = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if ($urandom_range(0, 2) == 0) begin
            da = 23'($urandom); base = 16'($urandom);
            pulse_dbg(da);
            serve(1, base, got, a, l, rdy, vld, rq);
            vectors++;
            if (!got || a !== da || l !== 8'd1 || vld !== 1'b1 || dbg_rdata !== base || qAddr.size() != 0) begin
               errors++; $display("FAIL rand_dbg[%0d]: got addr=%h len=%0d vld=%b rdata=%h want %h 1 1 %h", t, a, l, vld, dbg_rdata, da, base);
            end
         end else begin
            img = 2'($urandom); num = 7'($urandom); base = 16'($urandom);
            pulse_line(img, num);
            serve(WPL, base, got, a, l, rdy, vld, rq);
            mBank = ~mBank;
            bad = (qAddr.size() != WPL) ? 1 : 0;
            for (int i = 0; i < qAddr.size(); i++)
               if (qAddr[i] !== {mBank, 7'(i)} || qData[i] !== base + 16'(i)) bad++;
            vectors++;
            if (!got || a !== refLineAddr(img, num) || l !== 8'(WPL) || rdy !== 1'b1 || bad != 0) begin
               errors++; $display("FAIL rand_line[%0d]: got addr=%h len=%0d rdy=%b bad=%0d want %h %0d 1 0", t, a, l, rdy, bad, refLineAddr(img, num), WPL);
            end
         end
         @(negedge sys_clk);
         vectors++;
         if (line_bank !== mBank) begin errors++; $display("FAIL rand_bank[%0d]: got %b want %b", t, line_bank, mBank); end
         repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      end
   endtask

   initial begin
      img_sel = '0; line_num = '0; dbg_addr = '0;
      test_reset();
      test_line_fetch();
      test_debug_read();
      test_arbitration();
      test_overrun();
      test_len_err();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
